// File: rtl/fetch_unit.sv
// fetch_unit: NBBPU instruction fetch over a request/ready memory handshake.
// Define FETCH_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module fetch_unit #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] PC,
  input  logic        flush,
  output logic        mem_request,
  output logic [15:0] mem_address,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic        instruction_valid,
  output logic        fetch_fault
);
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQUEST, HOLD, FAULT} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, disc_q, disc_d, fault_q, fault_d, issue, tick;
  logic [15:0] addr_q, addr_d, instr_q, instr_d, fpc_q, fpc_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef FETCH_PREFETCH_EN
  logic buf_v_q, buf_v_d;
  logic [15:0] buf_q, buf_d, buf_a_q, buf_a_d;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      disc_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      fpc_q   <= '0;
      cnt_q   <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_v_q <= 1'b0;
      buf_q   <= '0;
      buf_a_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      disc_q  <= disc_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_PREFETCH_EN
      buf_v_q <= buf_v_d;
      buf_q   <= buf_d;
      buf_a_q <= buf_a_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    disc_d  = disc_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    tick    = 1'b0;
`ifdef FETCH_PREFETCH_EN
    buf_v_d = buf_v_q;
    buf_d   = buf_q;
    buf_a_d = buf_a_q;
`endif
    case (state_q)
      IDLE: issue = 1'b1;
      REQUEST:
        if (mem_ready) begin
          if (disc_q || flush) begin
            disc_d = 1'b0;
            issue  = 1'b1;
          end else begin
            instr_d = mem_rdata;
            fpc_d   = addr_q;
            req_d   = 1'b0;
            state_d = HOLD;
`ifdef FETCH_PREFETCH_EN
            addr_d  = addr_q + 16'd2;
            req_d   = 1'b1;
            cnt_d   = '0;
            buf_v_d = 1'b0;
`endif
          end
        end else begin
          tick = 1'b1;
          if (flush) disc_d = 1'b1;
        end
      HOLD:
`ifdef FETCH_PREFETCH_EN
        if (req_q) begin
          // a prefetch in flight cannot be withdrawn; abandon it through the discard path
          if (flush || (PC != fpc_q && PC != addr_q)) begin
            if (mem_ready) issue = 1'b1;
            else begin
              disc_d  = 1'b1;
              state_d = REQUEST;
              tick    = 1'b1;
            end
          end else if (mem_ready) begin
            buf_d   = mem_rdata;
            buf_a_d = addr_q;
            buf_v_d = 1'b1;
            req_d   = 1'b0;
          end else tick = 1'b1;
        end else if (flush || PC != fpc_q) begin
          buf_v_d = 1'b0;
          if (!flush && buf_v_q && PC == buf_a_q) begin
            instr_d = buf_q;
            fpc_d   = buf_a_q;
            addr_d  = buf_a_q + 16'd2;
            req_d   = 1'b1;
            cnt_d   = '0;
          end else issue = 1'b1;
        end
`else
        if (PC != fpc_q || flush) issue = 1'b1;
`endif
      default: ;
    endcase
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      if (WAIT_LIMIT != 0 && cnt_d == CW'(WAIT_LIMIT)) begin
        fault_d = 1'b1;
        req_d   = 1'b0;
        state_d = FAULT;
      end
    end
    if (issue) begin
      if (PC[0]) begin
        fault_d = 1'b1;
        req_d   = 1'b0;
        state_d = FAULT;
      end else begin
        addr_d  = PC;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = REQUEST;
      end
    end
  end
  always_comb begin
    mem_request       = req_q;
    mem_address       = addr_q;
    instruction       = instr_q;
    fetch_fault       = fault_q;
    instruction_valid = (state_q == HOLD) && (PC == fpc_q) && !flush;
  end
endmodule
